// File: rtl/lemmings_walker_pkg.sv
// Shared state encodings for the lemming walker family.
// The 3-bit values stay fixed so benches and sibling walkers decode them the same way.
package lemmings_walker_pkg;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    function automatic logic is_fall(input state_t s);
        return (s == FALL_L) || (s == FALL_R);
    endfunction

endpackage

// File: rtl/lemmings_fall_timer.sv
// Saturating fall-length counter: start loads 1, hold counts up, otherwise clears.
// over_limit flags a fall longer than SPLAT_CYCLES.
module lemmings_fall_timer #(
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic over_limit
);

    // Stopping at SPLAT_CYCLES+1 keeps a very long fall from wrapping back to a survivable count.
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SPLAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SPLAT_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(1);
        end else if (hold) begin
            if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign over_limit = (cnt > CNT_LIMIT);

endmodule

// File: rtl/lemmings_walker.sv
// Moore controller for one lemming: walk, turn on bumps, fall, dig, splat.
// Outputs decode only the registered state, so every input shows up one cycle later.
module lemmings_walker
    import lemmings_walker_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = 5,
    parameter bit DIG_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);

    state_t state;
    state_t next_state;
    logic   over_limit;
    logic   dig_req;
    logic   timer_start;
    logic   timer_hold;

    assign dig_req = dig && DIG_EN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WALK_L;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WALK_L: begin
                if (!ground)        next_state = FALL_L;
                else if (dig_req)   next_state = DIG_L;
                else if (bump_left) next_state = WALK_R;
            end
            WALK_R: begin
                if (!ground)         next_state = FALL_R;
                else if (dig_req)    next_state = DIG_R;
                else if (bump_right) next_state = WALK_L;
            end
            DIG_L:  if (!ground) next_state = FALL_L;
            DIG_R:  if (!ground) next_state = FALL_R;
            FALL_L: if (ground)  next_state = over_limit ? SPLAT : WALK_L;
            FALL_R: if (ground)  next_state = over_limit ? SPLAT : WALK_R;
            SPLAT:  next_state = SPLAT;
            default: next_state = WALK_L;
        endcase
    end

    // The counter tracks how many cycles aaah has been high, including the first.
    assign timer_start = is_fall(next_state) && !is_fall(state);
    assign timer_hold  = is_fall(next_state) && is_fall(state);

    lemmings_fall_timer #(
        .SPLAT_CYCLES(SPLAT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_fall_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (timer_start),
        .hold      (timer_hold),
        .over_limit(over_limit)
    );

    always_comb begin
        walk_left  = 1'b0;
        walk_right = 1'b0;
        aaah       = 1'b0;
        digging    = 1'b0;
        splat      = 1'b0;
        case (state)
            WALK_L:         walk_left  = 1'b1;
            WALK_R:         walk_right = 1'b1;
            FALL_L, FALL_R: aaah       = 1'b1;
            DIG_L, DIG_R:   digging    = 1'b1;
            SPLAT:          splat      = 1'b1;
            default:        ;
        endcase
    end

endmodule
